rpn_from_network_bridge_demux: RTL and testbench

Parametrised, packet-aware AXI-Stream demultiplexer between the network bridge receive path and the RPN control-API consumers (WNN repo, WNN node, and further reliability engines). It decodes the RPN message type from the first beat of each packet. It routes the whole packet, up to and including `tlast`, to one of `NUM_OUTPUTS` channels selected by a per-channel inclusive type range. Packets whose type matches no range are consumed and counted as drops.

---
 rtl/rpn_from_network_bridge_demux.sv | 181 ++++++++++++++++++
 tb/tb_rpn_from_network_bridge_demux.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rpn_from_network_bridge_demux.sv
// Packet-aware AXI-Stream demux: routes whole packets by the RPN message type in the first beat.
// Optional macro RPN_FROM_NB_DEMUX_OUTPUT_REG_EN adds a registered 2-entry skid buffer per channel.
module rpn_from_network_bridge_demux #(
   parameter int NUM_OUTPUTS              = 4,
   parameter int AXIS_DATA_WIDTH          = 512,
   parameter int AXIS_KEEP_WIDTH          = 64,
   parameter int AXIS_FROM_NB_TDEST_WIDTH = 16,
   parameter int AXIS_FROM_NB_TUSER_WIDTH = 16,
   parameter int RPN_MSG_TYPE_WIDTH       = 8,
   parameter logic [NUM_OUTPUTS*RPN_MSG_TYPE_WIDTH-1:0] ROUTE_LO = '0,
   parameter logic [NUM_OUTPUTS*RPN_MSG_TYPE_WIDTH-1:0] ROUTE_HI = '0
) (
   input  logic                                             i_clk,
   input  logic                                             i_ap_rst,
   input  logic                                             from_network_bridge_tvalid,
   output logic                                             from_network_bridge_tready,
   input  logic [AXIS_DATA_WIDTH-1:0]                       from_network_bridge_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0]                       from_network_bridge_tkeep,
   input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0]              from_network_bridge_tid,
   input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0]              from_network_bridge_tdest,
   input  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0]              from_network_bridge_tuser,
   input  logic                                             from_network_bridge_tlast,
   output logic [NUM_OUTPUTS-1:0]                           to_rpn_tvalid,
   input  logic [NUM_OUTPUTS-1:0]                           to_rpn_tready,
   output logic [NUM_OUTPUTS*AXIS_DATA_WIDTH-1:0]           to_rpn_tdata,
   output logic [NUM_OUTPUTS*AXIS_KEEP_WIDTH-1:0]           to_rpn_tkeep,
   output logic [NUM_OUTPUTS*AXIS_FROM_NB_TDEST_WIDTH-1:0]  to_rpn_tid,
   output logic [NUM_OUTPUTS*AXIS_FROM_NB_TDEST_WIDTH-1:0]  to_rpn_tdest,
   output logic [NUM_OUTPUTS*AXIS_FROM_NB_TUSER_WIDTH-1:0]  to_rpn_tuser,
   output logic [NUM_OUTPUTS-1:0]                           to_rpn_tlast,
   output logic [31:0]                                      o_drop_count,
   output logic                                             o_drop_pulse
);

   localparam int DW = AXIS_DATA_WIDTH;
   localparam int KW = AXIS_KEEP_WIDTH;
   localparam int TW = AXIS_FROM_NB_TDEST_WIDTH;
   localparam int UW = AXIS_FROM_NB_TUSER_WIDTH;
   localparam int MW = RPN_MSG_TYPE_WIDTH;
   localparam int PW = DW + KW + 2*TW + UW + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FWD  = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [NUM_OUTPUTS-1:0] sel_q, sel_d;
   logic [31:0]            drop_cnt_q, drop_cnt_d;
   logic                   rdy_en_q, rdy_en_d;

   logic [MW-1:0]          msg_type;
   logic [NUM_OUTPUTS-1:0] match, dec_oh, route_oh, ch_ready;
   logic                   drop_mode, in_hs, drop_pulse;
   logic [PW-1:0]          payload;

   assign msg_type = from_network_bridge_tdata[MW-1:0];
   assign payload  = {from_network_bridge_tdata, from_network_bridge_tkeep, from_network_bridge_tid,
                      from_network_bridge_tdest, from_network_bridge_tuser, from_network_bridge_tlast};

   // A channel whose LO exceeds HI can never satisfy both bounds, so it is disabled.
   generate
      for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_match
         assign match[gi] = (msg_type >= ROUTE_LO[gi*MW +: MW]) && (msg_type <= ROUTE_HI[gi*MW +: MW]);
      end
   endgenerate

   always_comb begin
      dec_oh = '0;
      for (int i = NUM_OUTPUTS - 1; i >= 0; i--) begin
         if (match[i]) begin
            dec_oh    = '0;
            dec_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      route_oh  = '0;
      drop_mode = 1'b0;
      case (state_q)
         ST_IDLE: begin
            route_oh  = dec_oh;
            drop_mode = ~|match;
         end
         ST_FWD:  route_oh  = sel_q;
         default: drop_mode = 1'b1;
      endcase
   end

   assign from_network_bridge_tready = rdy_en_q && (drop_mode || |(route_oh & ch_ready));
   assign in_hs        = from_network_bridge_tvalid && from_network_bridge_tready;
   assign drop_pulse   = in_hs && (state_q == ST_IDLE) && drop_mode;
   assign o_drop_pulse = drop_pulse;
   assign o_drop_count = drop_cnt_q;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      drop_cnt_d = drop_cnt_q;
      rdy_en_d   = 1'b1;
      if (drop_pulse && (drop_cnt_q != 32'hFFFF_FFFF))
         drop_cnt_d = drop_cnt_q + 32'd1;
      if (in_hs) begin
         case (state_q)
            ST_IDLE: begin
               sel_d = dec_oh;
               if (!from_network_bridge_tlast)
                  state_d = drop_mode ? ST_DROP : ST_FWD;
            end
            default: if (from_network_bridge_tlast) state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_ap_rst) begin
      if (i_ap_rst) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         drop_cnt_q <= '0;
         rdy_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         drop_cnt_q <= drop_cnt_d;
         rdy_en_q   <= rdy_en_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_ch
`ifdef RPN_FROM_NB_DEMUX_OUTPUT_REG_EN
         logic [PW-1:0] mem_q [2];
         logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
         logic [1:0]    cnt_q, cnt_d;
         logic          push, pop;

         assign push = in_hs && route_oh[gi];
         assign pop  = (cnt_q != 2'd0) && to_rpn_tready[gi];
         // Readiness comes from local occupancy only, breaking the tready path to the input.
         assign ch_ready[gi] = (cnt_q != 2'd2);

         always_comb begin
            wr_ptr_d = wr_ptr_q ^ push;
            rd_ptr_d = rd_ptr_q ^ pop;
            cnt_d    = cnt_q;
            if (push && !pop)
               cnt_d = cnt_q + 2'd1;
            else if (!push && pop)
               cnt_d = cnt_q - 2'd1;
         end

         always_ff @(posedge i_clk or posedge i_ap_rst) begin
            if (i_ap_rst) begin
               wr_ptr_q <= 1'b0;
               rd_ptr_q <= 1'b0;
               cnt_q    <= 2'd0;
            end else begin
               wr_ptr_q <= wr_ptr_d;
               rd_ptr_q <= rd_ptr_d;
               cnt_q    <= cnt_d;
            end
         end

         always_ff @(posedge i_clk) begin
            if (push)
               mem_q[wr_ptr_q] <= payload;
         end

         assign to_rpn_tvalid[gi] = (cnt_q != 2'd0);
         assign {to_rpn_tdata[gi*DW +: DW], to_rpn_tkeep[gi*KW +: KW], to_rpn_tid[gi*TW +: TW],
                 to_rpn_tdest[gi*TW +: TW], to_rpn_tuser[gi*UW +: UW], to_rpn_tlast[gi]} = mem_q[rd_ptr_q];
`else
         assign ch_ready[gi]      = to_rpn_tready[gi];
         assign to_rpn_tvalid[gi] = rdy_en_q && from_network_bridge_tvalid && route_oh[gi];
         assign {to_rpn_tdata[gi*DW +: DW], to_rpn_tkeep[gi*KW +: KW], to_rpn_tid[gi*TW +: TW],
                 to_rpn_tdest[gi*TW +: TW], to_rpn_tuser[gi*UW +: UW], to_rpn_tlast[gi]} = payload;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_rpn_from_network_bridge_demux.sv
// Directed bench for rpn_from_network_bridge_demux (pass-through build): two channels,
// routes {0..3} and {8..255}, so types 4..7 are dropped.
module tb_rpn_from_network_bridge_demux;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int KW = 4;
   localparam int TW = 4;
   localparam int UW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [DW-1:0]   in_data = '0;
   logic [KW-1:0]   in_keep = 4'hF;
   logic [TW-1:0]   in_id = 4'h3;
   logic [TW-1:0]   in_dest = 4'h5;
   logic [UW-1:0]   in_user = 4'h6;
   logic            in_last = 1'b0;
   logic [N-1:0]    out_valid;
   logic [N-1:0]    out_ready = 2'b11;
   logic [N*DW-1:0] out_data;
   logic [N*KW-1:0] out_keep;
   logic [N*TW-1:0] out_id;
   logic [N*TW-1:0] out_dest;
   logic [N*UW-1:0] out_user;
   logic [N-1:0]    out_last;
   logic [31:0]     drop_count;
   logic            drop_pulse;

   int tests  = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rpn_from_network_bridge_demux #(
      .NUM_OUTPUTS(N), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW),
      .AXIS_FROM_NB_TDEST_WIDTH(TW), .AXIS_FROM_NB_TUSER_WIDTH(UW), .RPN_MSG_TYPE_WIDTH(8),
      .ROUTE_LO({8'd8, 8'd0}), .ROUTE_HI({8'd255, 8'd3})
   ) dut (
      .i_clk(clk), .i_ap_rst(rst),
      .from_network_bridge_tvalid(in_valid), .from_network_bridge_tready(in_ready),
      .from_network_bridge_tdata(in_data), .from_network_bridge_tkeep(in_keep),
      .from_network_bridge_tid(in_id), .from_network_bridge_tdest(in_dest),
      .from_network_bridge_tuser(in_user), .from_network_bridge_tlast(in_last),
      .to_rpn_tvalid(out_valid), .to_rpn_tready(out_ready), .to_rpn_tdata(out_data),
      .to_rpn_tkeep(out_keep), .to_rpn_tid(out_id), .to_rpn_tdest(out_dest),
      .to_rpn_tuser(out_user), .to_rpn_tlast(out_last),
      .o_drop_count(drop_count), .o_drop_pulse(drop_pulse)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one beat for exactly one cycle (caller sits just after a rising edge).
   task automatic beat(input string tag, input logic [31:0] d, input logic l,
                       input logic [1:0] ev, input logic ep);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      $display("[TB] %s data=%h last=%0d tvalid=%b tready=%0d pulse=%0d", tag, d, l, out_valid, in_ready, drop_pulse);
      chk({tag, ".tvalid"}, 64'(out_valid), 64'(ev));
      chk({tag, ".tready"}, 64'(in_ready), 64'd1);
      chk({tag, ".pulse"}, 64'(drop_pulse), 64'(ep));
      if (ev != 2'b00) begin
         chk({tag, ".tdata"}, 64'(out_data), {d, d});
         chk({tag, ".tlast"}, 64'(out_last), {62'd0, l, l});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.tvalid", 64'(out_valid), 64'd0);
      chk("rst.tready", 64'(in_ready), 64'd0);
      chk("rst.count", 64'(drop_count), 64'd0);
      chk("rst.pulse", 64'(drop_pulse), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst.tready_low", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("post_rst.tready_high", 64'(in_ready), 64'd1);
      chk("post_rst.idle_tvalid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;

      // 3-beat packet, type 9 -> channel 1 only; sideband forwarded to both slices
      beat("p1.b0", 32'h1111_1109, 1'b0, 2'b10, 1'b0);
      beat("p1.b1", 32'h2222_2200, 1'b0, 2'b10, 1'b0);
      beat("p1.b2", 32'h3333_3333, 1'b1, 2'b10, 1'b0);
      chk("p1.tkeep", 64'(out_keep), 64'hFF);
      chk("p1.tid_tdest_tuser", {out_id, out_dest, out_user}, 64'h33_55_66);

      // Header type 2 latches channel 0 even though body low bytes say 9
      beat("p2.b0", 32'h0000_0002, 1'b0, 2'b01, 1'b0);
      beat("p2.b1", 32'hAAAA_AA09, 1'b0, 2'b01, 1'b0);
      beat("p2.b2", 32'hBBBB_BB09, 1'b1, 2'b01, 1'b0);

      // 4-beat packet, type 6 -> dropped, one pulse, count 0 -> 1
      beat("p3.b0", 32'h0000_0006, 1'b0, 2'b00, 1'b1);
      chk("p3.count_after_hdr", 64'(drop_count), 64'd1);
      beat("p3.b1", 32'h0000_0000, 1'b0, 2'b00, 1'b0);
      beat("p3.b2", 32'h0000_0009, 1'b0, 2'b00, 1'b0);
      beat("p3.b3", 32'h0000_0001, 1'b1, 2'b00, 1'b0);
      @(negedge clk);
      chk("p3.count", 64'(drop_count), 64'd1);
      @(posedge clk);
      #1;

      // Back-to-back single-beat packets, one per cycle, alternating channels
      beat("b2b.0", 32'h0000_0100, 1'b1, 2'b01, 1'b0);
      beat("b2b.1", 32'h0000_0209, 1'b1, 2'b10, 1'b0);
      beat("b2b.2", 32'h0000_0300, 1'b1, 2'b01, 1'b0);
      beat("b2b.3", 32'h0000_0409, 1'b1, 2'b10, 1'b0);

      // Range boundaries: 3 (top of ch0), 8 (bottom of ch1), 7 (gap -> drop)
      beat("bnd.3", 32'h0000_0003, 1'b1, 2'b01, 1'b0);
      beat("bnd.8", 32'h0000_0008, 1'b1, 2'b10, 1'b0);
      beat("bnd.7", 32'h0000_0007, 1'b1, 2'b00, 1'b1);
      @(negedge clk);
      chk("bnd.count", 64'(drop_count), 64'd2);
      @(posedge clk);
      #1;

      // Back-pressure on channel 1 mid-packet: input stalls, payload held
      beat("bp.b0", 32'h0000_000A, 1'b0, 2'b10, 1'b0);
      out_ready = 2'b01;
      in_valid  = 1'b1;
      in_data   = 32'hCAFE_F00D;
      in_last   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         $display("[TB] bp.stall%0d tvalid=%b tready=%0d data=%h", i, out_valid, in_ready, out_data[63:32]);
         chk("bp.stall_tready", 64'(in_ready), 64'd0);
         chk("bp.stall_data", 64'({out_valid, out_data[63:32]}), {30'd0, 2'b10, 32'hCAFE_F00D});
         @(posedge clk);
         #1;
      end
      out_ready = 2'b11;
      in_valid  = 1'b0;
      beat("bp.b1", 32'hCAFE_F00D, 1'b0, 2'b10, 1'b0);
      beat("bp.b2", 32'h0000_0001, 1'b1, 2'b10, 1'b0);

      // Reset in the middle of a forwarded packet
      beat("rf.b0", 32'h0000_0009, 1'b0, 2'b10, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("rf.rst_count", 64'(drop_count), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rf.no_stale_tvalid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      beat("rf.type0", 32'h5555_5500, 1'b1, 2'b01, 1'b0);
      @(negedge clk);
      chk("rf.count", 64'(drop_count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
